regf_wb_arb: RTL
================

# regf_wb_arb

Write-back arbiter for register file port C. Collects write-back requests from NREQ producers (ALU, load unit, extension unit), grants at most one per cycle in round-robin order, and drives the single registered port C write (wec, addrc, datac). Port C also feeds the scoreboard's clear path, so the arbiter must never issue a write the scoreboard cannot record.

## Interface
- WIDTH, 5: register address width
- DWIDTH, 32: data width
- NREQ, 3: number of requesters; index 0 = ALU, 1 = load, 2 = extension
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester write-back request; held until granted
- req_addr  in  NREQ*WIDTH  flattened destination addresses; slice i = [i*WIDTH +: WIDTH]
- req_data  in  NREQ*DWIDTH  flattened write data, sliced the same way
- halt  in  1  system halt; the scoreboard is frozen while asserted
- flush_pipeline  in  1  pipeline flush; discards the staged write
- grant  out  NREQ  one-hot grant, combinational, same cycle as req
- wec  out  1  port C write enable
- addrc  out  WIDTH  port C write address
- datac  out  DWIDTH  port C write data
- wb_busy  out  1  any req asserted, or a staged write valid; contributes to safe_switch

## Operation
- Handshake: requester i raises req[i] with stable addr/data. A transfer occurs on the edge where req[i] and grant[i] are both high. The requester deasserts or presents new data after that edge. Address and data must not change while req[i] is high and ungranted.
- Grant condition: !halt && !flush_pipeline && !reset. Otherwise grant = 0.
- Pick: rotate-priority search starting at index ptr, wrapping modulo NREQ. Take the first asserted req. grant is one-hot or zero.
- ptr: on a transfer edge, ptr <= (granted index + 1) mod NREQ. With no transfer, ptr holds.
- Staging register (valid_q, addr_q, data_q):
  - On a transfer edge it loads the granted slice with valid_q = 1.
  - Else, if !halt, valid_q <= 0.
  - Else (halt), the register holds.
- wec = valid_q && !halt. addrc = addr_q, datac = data_q. Writes are deferred, never dropped, across halt.
- Flush: at a flush edge valid_q <= 0. ptr holds. No grant in the flush cycle.
- Same-address requests from two producers in one cycle are granted in round-robin order on consecutive cycles. No merging. The later one wins in the register file.
- wb_busy = |req || valid_q.
- Reset values: wec = 0, addrc = 0, datac = 0, valid_q = 0, ptr = 0, grant = 0, wb_busy = 0 (req is low during reset).
- Reset mid-operation clears the staged write immediately (asynchronous). Pending requests remain the requesters' responsibility.

## Timing
- Latency: req[i] high with grant[i] high in cycle t gives wec/addrc/datac for that write in cycle t+1.
- Throughput: one write per cycle sustained. With all NREQ requesting continuously, each is granted once every NREQ cycles. Worst-case wait is NREQ-1 cycles when not halted.
- Halt entered in cycle t: wec drops in cycle t. The staged write reappears on wec in the first non-halt cycle and retires at that edge. The next grant is in that same cycle, so there is no bubble.
- Halt and flush in the same cycle: flush wins and the staged write is discarded.
- Grant is combinational from req, ptr, halt and flush. The path is a NREQ-wide rotate plus priority encode; it must close within one cycle ahead of the port C register.

## Structure
- Shared package regf_pkg holds:
  - WIDTH/DWIDTH defaults
  - requester index constants REQ_ALU = 0, REQ_LD = 1, REQ_EXT = 2
  - the NREQ default
- Sub-module regf_rr_pick (combinational): inputs req[NREQ], ptr, enable; outputs one-hot grant and a binary index. It is reused by future read-port arbitration.
- Top module: ptr register, staging register, slice muxes, wec gating.

## Test plan
- Reset released, no requests: wec = 0, addrc = 0, wb_busy = 0. req[1] = 1, addr 5'd7, data 32'hDEADBEEF gives grant = 3'b010 that cycle, then wec = 1, addrc = 7, datac = DEADBEEF the next cycle; ptr = 2.
- req = 3'b111 held for 6 cycles from ptr = 0: grant sequence 001, 010, 100, 001, 010, 100. wec is asserted on every cycle 1 through 6.
- Staged write to r3, then halt for 4 cycles: wec = 0 during halt and grant = 0. wec = 1 with addrc = 3 in the first cycle after halt, exactly once.
- Staged write to r9 with flush_pipeline pulsed: wec stays 0 the next cycle. No grant during flush; ptr unchanged.
- req[0] and req[2] both target r4 with data 1 and 2, ptr = 1: req[2] is written first, then req[0]. The final port C sequence is (4,2), (4,1).
- Async reset asserted while valid_q = 1 and halt = 1: wec, addrc and datac go to 0 without a clock edge. After release, ptr = 0.

Source files
------------

// File: rtl/regf_pkg.sv
// Shared constants for the register-file port C write-back path.
// Requester indices fix the round-robin slot of each producer.
package regf_pkg;

    localparam int REGF_WIDTH  = 5;
    localparam int REGF_DWIDTH = 32;
    localparam int REGF_NREQ   = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;
    localparam int REQ_EXT = 2;

    // A single requester still needs a 1-bit pointer so the ports stay legal.
    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regf_rr_pick.sv
// Combinational rotate-priority picker: first asserted request at or after ptr,
// wrapping modulo NREQ. Shared with future read-port arbitration.
module regf_rr_pick
    import regf_pkg::*;
#(
    parameter int NREQ = REGF_NREQ,
    parameter int PW   = ptr_bits(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);

    logic [PW:0] pos;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(NREQ)) begin
                pos = pos - (PW+1)'(NREQ);
            end
            if (enable && !found && req[pos[PW-1:0]]) begin
                grant[pos[PW-1:0]] = 1'b1;
                idx                = pos[PW-1:0];
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regf_wb_arb.sv
// Round-robin write-back arbiter for register file port C. A granted request is
// staged for one cycle; halt freezes the stage so writes are deferred, not dropped.
module regf_wb_arb
    import regf_pkg::*;
#(
    parameter int WIDTH  = REGF_WIDTH,
    parameter int DWIDTH = REGF_DWIDTH,
    parameter int NREQ   = REGF_NREQ
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_addr,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    input  logic                     halt,
    input  logic                     flush_pipeline,
    output logic [NREQ-1:0]          grant,
    output logic                     wec,
    output logic [WIDTH-1:0]         addrc,
    output logic [DWIDTH-1:0]        datac,
    output logic                     wb_busy
);

    localparam int PW = ptr_bits(NREQ);

    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     grant_idx;
    logic [PW-1:0]     ptr_next;
    logic              pick_en;
    logic              transfer;
    logic              valid_q;
    logic [WIDTH-1:0]  addr_q;
    logic [WIDTH-1:0]  addr_sel;
    logic [DWIDTH-1:0] data_q;
    logic [DWIDTH-1:0] data_sel;

    // No grant while halted, so the scoreboard never misses a clear.
    assign pick_en = !halt && !flush_pipeline && !reset;

    regf_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .enable (pick_en),
        .grant  (grant),
        .idx    (grant_idx)
    );

    assign transfer = |grant;
    assign ptr_next = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);

    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                addr_sel = req_addr[i*WIDTH +: WIDTH];
                data_sel = req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (transfer) begin
            ptr_q <= ptr_next;
        end
    end

    // Flush outranks halt: a write frozen by halt is discarded by a flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (transfer) begin
            valid_q <= 1'b1;
            addr_q  <= addr_sel;
            data_q  <= data_sel;
        end else if (flush_pipeline) begin
            valid_q <= 1'b0;
        end else if (!halt) begin
            valid_q <= 1'b0;
        end
    end

    assign wec     = valid_q && !halt;
    assign addrc   = addr_q;
    assign datac   = data_q;
    assign wb_busy = (|req) || valid_q;

endmodule
